// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game datapath.
// Covers match mode, match results and the point generator.
package snake_pkg;

    typedef enum logic {
        MENU = 1'b0,
        GAME = 1'b1
    } game_mode;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_WIN1 = 2'd1,
        R_WIN2 = 2'd2,
        R_DRAW = 2'd3
    } result_t;

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_SEARCH = 2'd1,
        P_OFFER  = 2'd2
    } pgen_state_t;

    // Polynomial x^16 + x^14 + x^13 + x^11 + 1 in right-shift form:
    // the feedback bit is the XOR of bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/point_spawner.sv
// Point tile generator: free-running LFSR, off-map rejection,
// and a valid/ack offer with a single pending request slot.
module point_spawner
    import snake_pkg::*;
#(
    parameter int          MAP_W     = 32,
    parameter int          MAP_H     = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          XW        = $clog2(MAP_W),
    parameter int          YW        = $clog2(MAP_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          point_ack,
    output logic          point_valid,
    output logic [XW-1:0] point_x,
    output logic [YW-1:0] point_y
);

    logic [15:0]   lfsr;
    pgen_state_t   pstate;
    logic          pending;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic          cand_ok;

    assign cand_x  = lfsr[XW-1:0];
    assign cand_y  = lfsr[XW+YW-1:XW];
    assign cand_ok = (int'(cand_x) < MAP_W) &&
                     (int'(cand_y) < MAP_H);

    // LFSR steps every cycle so point placement depends on timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Search until an on-map candidate appears, then hold it until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate      <= P_IDLE;
            pending     <= 1'b0;
            point_valid <= 1'b0;
            point_x     <= '0;
            point_y     <= '0;
        end else begin
            unique case (pstate)
                P_IDLE: begin
                    if (req) begin
                        pstate <= P_SEARCH;
                    end
                end
                P_SEARCH: begin
                    if (req) begin
                        pending <= 1'b1;
                    end
                    if (cand_ok) begin
                        point_x     <= cand_x;
                        point_y     <= cand_y;
                        point_valid <= 1'b1;
                        pstate      <= P_OFFER;
                    end
                end
                P_OFFER: begin
                    if (point_ack) begin
                        point_valid <= 1'b0;
                        pending     <= 1'b0;
                        pstate      <= (pending || req) ? P_SEARCH : P_IDLE;
                    end else if (req) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    pstate <= P_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/game_outcome_ctrl.sv
// Match controller: consumes collision pulses, runs the match FSM,
// keeps scores and tallies, and requests new point tiles.
module game_outcome_ctrl
    import snake_pkg::*;
#(
    parameter int          MAP_W      = 32,
    parameter int          MAP_H      = 24,
    parameter int          SCORE_W    = 8,
    parameter int          HOLD_TICKS = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          XW         = $clog2(MAP_W),
    parameter int          YW         = $clog2(MAP_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_div,
    input  logic               start,
    input  logic               eaten1,
    input  logic               eaten2,
    input  logic               won,
    input  logic               lost,
    input  logic               draw,
    output game_mode           mode,
    output result_t            result,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] tally1,
    output logic [SCORE_W-1:0] tally2,
    output logic               point_valid,
    output logic [XW-1:0]      point_x,
    output logic [YW-1:0]      point_y,
    input  logic               point_ack
);

    localparam logic [1:0] ST_MENU   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    localparam int          HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          eaten1_q;
    logic          eaten2_q;
    logic          clk_div_q;
    logic          rise1;
    logic          rise2;
    logic          div_rise;
    logic          in_menu;
    logic          in_play;
    logic          point_req;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v
    );
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    assign in_menu  = (state == ST_MENU);
    assign in_play  = (state == ST_PLAY);
    assign rise1    = eaten1 & ~eaten1_q;
    assign rise2    = eaten2 & ~eaten2_q;
    assign div_rise = clk_div & ~clk_div_q;

    // A match start asks for the first point; each eat asks for another.
    assign point_req = (in_menu && start) ||
                       (in_play && (rise1 || rise2));

    assign mode = in_play ? GAME : MENU;

    // Previous-value registers for the level inputs we edge-detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eaten1_q  <= 1'b0;
            eaten2_q  <= 1'b0;
            clk_div_q <= 1'b0;
        end else begin
            eaten1_q  <= eaten1;
            eaten2_q  <= eaten2;
            clk_div_q <= clk_div;
        end
    end

    // Match FSM with score, tally and result-hold bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_MENU;
            result   <= R_NONE;
            score1   <= '0;
            score2   <= '0;
            tally1   <= '0;
            tally2   <= '0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                ST_MENU: begin
                    if (start) begin
                        state  <= ST_PLAY;
                        score1 <= '0;
                        score2 <= '0;
                        result <= R_NONE;
                    end
                end
                ST_PLAY: begin
                    if (rise1) begin
                        score1 <= sat_inc(score1);
                    end
                    if (rise2) begin
                        score2 <= sat_inc(score2);
                    end
                    priority case (1'b1)
                        draw: begin
                            state  <= ST_RESULT;
                            result <= R_DRAW;
                        end
                        lost: begin
                            state  <= ST_RESULT;
                            result <= R_WIN2;
                            tally2 <= sat_inc(tally2);
                        end
                        won: begin
                            state  <= ST_RESULT;
                            result <= R_WIN1;
                            tally1 <= sat_inc(tally1);
                        end
                        default: ;
                    endcase
                end
                ST_RESULT: begin
                    if (div_rise) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= ST_MENU;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_MENU;
                end
            endcase
        end
    end

    point_spawner #(
        .MAP_W     (MAP_W),
        .MAP_H     (MAP_H),
        .LFSR_SEED (LFSR_SEED),
        .XW        (XW),
        .YW        (YW)
    ) u_spawner (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (point_req),
        .point_ack   (point_ack),
        .point_valid (point_valid),
        .point_x     (point_x),
        .point_y     (point_y)
    );

endmodule

// File: tb/tb_game_outcome_ctrl.sv
// Bench for game_outcome_ctrl: directed match sequences, with point
// offers checked by a queue-driven monitor against an LFSR model.
module tb_game_outcome_ctrl;
    import snake_pkg::*;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clk_div   = 1'b0;
    logic       start     = 1'b0;
    logic       eaten1    = 1'b0;
    logic       eaten2    = 1'b0;
    logic       won       = 1'b0;
    logic       lost      = 1'b0;
    logic       draw      = 1'b0;
    logic       point_ack = 1'b0;
    game_mode   mode;
    result_t    result;
    logic [7:0] score1;
    logic [7:0] score2;
    logic [7:0] tally1;
    logic [7:0] tally2;
    logic       point_valid;
    logic [4:0] point_x;
    logic [4:0] point_y;

    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];
    int tag   = 0;
    bit relax = 1'b0;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic        pv = 1'b0;
    logic [4:0]  px = 5'd0;
    logic [4:0]  py = 5'd0;

    always #5 clk = ~clk;

    game_outcome_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_div     (clk_div),
        .start       (start),
        .eaten1      (eaten1),
        .eaten2      (eaten2),
        .won         (won),
        .lost        (lost),
        .draw        (draw),
        .mode        (mode),
        .result      (result),
        .score1      (score1),
        .score2      (score2),
        .tally1      (tally1),
        .tally2      (tally2),
        .point_valid (point_valid),
        .point_x     (point_x),
        .point_y     (point_y),
        .point_ack   (point_ack)
    );

    // Reference x^16+x^14+x^13+x^11+1 LFSR, m_prev = value before last edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                       m_lfsr[15:1]};
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_offer();
        tag++;
        exp_q.push_back(tag);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!point_valid && n < 32) begin
            tick();
            n++;
        end
        chk(name, int'(point_valid), 1);
    endtask

    task automatic do_ack();
        point_ack = 1'b1;
        tick();
        point_ack = 1'b0;
        chk("ack_drops_valid", int'(point_valid), 0);
    endtask

    task automatic div_edge();
        clk_div = 1'b1;
        tick();
        clk_div = 1'b0;
        tick();
    endtask

    task automatic eat1_pulse();
        eaten1 = 1'b1;
        tick();
        eaten1 = 1'b0;
    endtask

    // Offer monitor: each new offer pops one expectation from the queue
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (point_valid && !pv) begin
                chk("offer_y_on_map", int'(point_y < 5'd24), 1);
                chk("offer_x", point_x, m_prev[4:0]);
                chk("offer_y", point_y, m_prev[9:5]);
                if (!relax) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_offer: got (%0d,%0d) want none",
                                 point_x, point_y);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end else if (point_valid && pv) begin
                chk("offer_stable_x", point_x, px);
                chk("offer_stable_y", point_y, py);
            end
            pv = point_valid;
            px = point_x;
            py = point_y;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stimulus
        #12;
        chk("rst_mode", mode, MENU);
        chk("rst_result", result, R_NONE);
        chk("rst_score1", score1, 0);
        chk("rst_tally2", tally2, 0);
        chk("rst_valid", int'(point_valid), 0);
        chk("rst_px", point_x, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // match 1: start and first point
        push_offer();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_mode", mode, GAME);
        chk("start_score1", score1, 0);
        chk("start_score2", score2, 0);
        wait_valid("first_offer");
        do_ack();

        // eaten1 held 5 cycles counts once
        push_offer();
        eaten1 = 1'b1;
        repeat (5) tick();
        eaten1 = 1'b0;
        chk("held_eat_score1", score1, 1);
        wait_valid("held_eat_offer");
        do_ack();

        // both snakes eat together: one offer
        push_offer();
        eaten1 = 1'b1;
        eaten2 = 1'b1;
        tick();
        eaten1 = 1'b0;
        eaten2 = 1'b0;
        chk("dual_score1", score1, 2);
        chk("dual_score2", score2, 1);
        wait_valid("dual_offer");
        do_ack();
        repeat (20) tick();
        chk("dual_single_offer", exp_q.size(), 0);

        // lost beats won
        lost = 1'b1;
        won  = 1'b1;
        tick();
        lost = 1'b0;
        won  = 1'b0;
        chk("lw_mode", mode, MENU);
        chk("lw_result", result, R_WIN2);
        chk("lw_tally2", tally2, 1);
        chk("lw_tally1", tally1, 0);
        chk("lw_score1_held", score1, 2);

        // start ignored during the result hold
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_start_ign", mode, MENU);
        repeat (15) div_edge();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold15_mode", mode, MENU);
        chk("hold15_result", result, R_WIN2);
        div_edge();
        chk("menu_result_kept", result, R_WIN2);

        // match 2
        push_offer();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("m2_mode", mode, GAME);
        chk("m2_score1", score1, 0);
        chk("m2_result", result, R_NONE);
        wait_valid("m2_offer");
        do_ack();

        // pending request while an offer is held, third is dropped
        push_offer();
        eat1_pulse();
        wait_valid("pend_first");
        push_offer();
        eaten2 = 1'b1;
        tick();
        eaten2 = 1'b0;
        tick();
        eat1_pulse();
        repeat (10) tick();
        chk("pend_held_valid", int'(point_valid), 1);
        do_ack();
        wait_valid("pend_second");
        do_ack();
        repeat (20) tick();
        chk("pend_third_dropped", exp_q.size(), 0);
        chk("pend_valid_idle", int'(point_valid), 0);
        chk("pend_score1", score1, 2);
        chk("pend_score2", score2, 1);

        // draw beats lost
        draw = 1'b1;
        lost = 1'b1;
        tick();
        draw = 1'b0;
        lost = 1'b0;
        chk("dl_result", result, R_DRAW);
        chk("dl_tally2", tally2, 1);
        chk("dl_tally1", tally1, 0);
        repeat (16) div_edge();

        // match 3: score saturation
        push_offer();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("m3_mode", mode, GAME);
        wait_valid("m3_offer");
        do_ack();
        relax     = 1'b1;
        point_ack = 1'b1;
        repeat (255) begin
            eat1_pulse();
            tick();
        end
        chk("sat_score1_255", score1, 255);
        eat1_pulse();
        tick();
        chk("sat_score1_hold", score1, 255);
        repeat (40) tick();
        point_ack = 1'b0;
        relax     = 1'b0;
        chk("sat_drained", int'(point_valid), 0);

        // async reset in the middle of an offer
        push_offer();
        eat1_pulse();
        chk("sat_score1_again", score1, 255);
        wait_valid("rst_offer");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(point_valid), 0);
        chk("arst_mode", mode, MENU);
        chk("arst_score1", score1, 0);
        chk("arst_tally2", tally2, 0);
        chk("arst_result", result, R_NONE);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", int'(point_valid), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
